// File: rtl/decode_pipe_reg.sv
// ---------------------------------------------------------------------------
// decode_pipe_reg
// Generic inter-stage pipeline register. It carries an opaque WIDTH-bit
// payload between a producer and a consumer stage using a valid/ready
// handshake. An optional skid entry (SKID=1) makes in_ready purely
// registered. A synchronous flush kills every held and incoming entry.
// Saturating counters record stall cycles and flushes that discarded work.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous kill of held and incoming entries
//   in_valid   in   producer has payload
//   in_ready   out  block can accept payload this cycle
//   in_data    in   producer payload [WIDTH]
//   out_valid  out  main entry holds valid payload
//   out_ready  in   consumer accepts payload this cycle
//   out_data   out  main-entry payload [WIDTH]
//   cnt_clr    in   synchronous clear of both counters
//   stall_cnt  out  saturating count of out_valid && !out_ready cycles [CNT_W]
//   flush_cnt  out  saturating count of flushes that hit a valid entry [CNT_W]
// ---------------------------------------------------------------------------
module decode_pipe_reg #(
    parameter int WIDTH          = 64,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   r_skid;
    logic [WIDTH-1:0]   w_main_nxt;
    logic [WIDTH-1:0]   w_skid_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_stall;

    // The skid entry is only ever valid behind a valid main entry, so the
    // main entry alone tells whether anything is held.
    assign w_out_valid = (r_state != ST_EMPTY);

    generate
        if (SKID != 0) begin : g_ready_reg
            // Registered ready: derived only from the state register.
            assign w_in_ready = (r_state != ST_SKID);
        end else begin : g_ready_comb
            // Single entry: accept when empty or when it drains this cycle.
            assign w_in_ready = (r_state == ST_EMPTY) || out_ready;
        end
    endgenerate

    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = w_out_valid && out_ready;
    assign w_stall    = w_out_valid && !out_ready;

    // Next-state and payload steering for the main/skid entries.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Flush overrides any transfer seen in the same cycle.
            w_state_nxt = ST_EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                w_main_nxt = DATA_ZERO;
                w_skid_nxt = DATA_ZERO;
            end else begin
                w_main_nxt = r_main;
                w_skid_nxt = r_skid;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = in_data;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = in_data;
                    end else if (w_in_xfer && (SKID != 0)) begin
                        // Consumer stalled: park the new payload behind main.
                        w_state_nxt = ST_SKID;
                        w_skid_nxt  = in_data;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_main_nxt  = r_skid;
                    end else begin
                        w_state_nxt = ST_SKID;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= DATA_ZERO;
            r_skid  <= DATA_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Saturating stall counter; clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= CNT_ZERO;
        end else if (cnt_clr) begin
            r_stall_cnt <= CNT_ZERO;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    // Saturating flush counter; only flushes that discard a valid entry count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= CNT_ZERO;
        end else if (cnt_clr) begin
            r_flush_cnt <= CNT_ZERO;
        end else if (flush && w_out_valid && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end else begin
            r_flush_cnt <= r_flush_cnt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_decode_pipe_reg.sv
// Bench for decode_pipe_reg: one skid instance (CNT_W=4, clear on flush)
// and one single-entry instance (payload held on flush). Inputs are driven
// on the falling edge and outputs compared 1 time unit later.
module tb_decode_pipe_reg;

    logic        clk;
    logic        rst;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
    logic [63:0] a_in_data, a_out_data;
    logic [3:0]  a_stall_cnt, a_flush_cnt;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
    logic [63:0] b_in_data, b_out_data;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    int total;
    int bad;

    typedef struct {
        bit          sel;
        logic        fl;
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        clr;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_od;
        logic [15:0] e_st;
        logic [15:0] e_fc;
    } vec_t;

    vec_t vecs[$];

    decode_pipe_reg #(.WIDTH(64), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .cnt_clr(a_cnt_clr), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    decode_pipe_reg #(.WIDTH(64), .SKID(0), .CLEAR_ON_FLUSH(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .cnt_clr(b_cnt_clr), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit sel, input logic fl, input logic iv, input logic [63:0] d,
                       input logic ordy, input logic clr, input logic e_ir, input logic e_ov,
                       input logic [63:0] e_od, input logic [15:0] e_st, input logic [15:0] e_fc);
        vec_t v;
        v.sel = sel; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_st = e_st; v.e_fc = e_fc;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        if (v.sel == 1'b0) begin
            a_flush = v.fl; a_in_valid = v.iv; a_in_data = v.d;
            a_out_ready = v.ordy; a_cnt_clr = v.clr;
            #1;
            chk($sformatf("a%0d in_ready", idx),  64'(a_in_ready),  64'(v.e_ir));
            chk($sformatf("a%0d out_valid", idx), 64'(a_out_valid), 64'(v.e_ov));
            chk($sformatf("a%0d out_data", idx),  a_out_data,       v.e_od);
            chk($sformatf("a%0d stall_cnt", idx), 64'(a_stall_cnt), 64'(v.e_st));
            chk($sformatf("a%0d flush_cnt", idx), 64'(a_flush_cnt), 64'(v.e_fc));
        end else begin
            b_flush = v.fl; b_in_valid = v.iv; b_in_data = v.d;
            b_out_ready = v.ordy; b_cnt_clr = v.clr;
            #1;
            chk($sformatf("b%0d in_ready", idx),  64'(b_in_ready),  64'(v.e_ir));
            chk($sformatf("b%0d out_valid", idx), 64'(b_out_valid), 64'(v.e_ov));
            chk($sformatf("b%0d out_data", idx),  b_out_data,       v.e_od);
            chk($sformatf("b%0d stall_cnt", idx), 64'(b_stall_cnt), 64'(v.e_st));
            chk($sformatf("b%0d flush_cnt", idx), 64'(b_flush_cnt), 64'(v.e_fc));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 64'h0; a_out_ready = 1'b0; a_cnt_clr = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 64'h0; b_out_ready = 1'b0; b_cnt_clr = 1'b0;

        // Each row: inputs for one cycle, outputs expected before the next edge.
        //   sel fl iv data         or clr  ir ov out_data     stall flush
        // Streaming 1..8, one cycle behind, no stalls.
        add(0, 0, 1, 64'h1,        1, 0,  1, 0, 64'h0,       16'd0, 16'd0);
        for (int k = 2; k <= 8; k++) begin
            add(0, 0, 1, 64'(k),   1, 0,  1, 1, 64'(k - 1),  16'd0, 16'd0);
        end
        add(0, 0, 0, 64'h0,        1, 0,  1, 1, 64'h8,       16'd0, 16'd0);
        add(0, 0, 0, 64'h0,        0, 0,  1, 0, 64'h8,       16'd0, 16'd0);
        // Backpressure into the skid entry, then drain 0xA then 0xB.
        add(0, 0, 1, 64'hA,        0, 0,  1, 0, 64'h8,       16'd0, 16'd0);
        add(0, 0, 1, 64'hB,        0, 0,  1, 1, 64'hA,       16'd0, 16'd0);
        add(0, 0, 1, 64'hC,        0, 0,  0, 1, 64'hA,       16'd1, 16'd0);
        add(0, 0, 0, 64'h0,        0, 0,  0, 1, 64'hA,       16'd2, 16'd0);
        add(0, 0, 0, 64'h0,        1, 0,  0, 1, 64'hA,       16'd3, 16'd0);
        add(0, 0, 0, 64'h0,        1, 0,  1, 1, 64'hB,       16'd3, 16'd0);
        add(0, 0, 0, 64'h0,        1, 0,  1, 0, 64'hB,       16'd3, 16'd0);
        // Refill to SKID, flush with an offered 0xC.
        add(0, 0, 1, 64'hA,        0, 0,  1, 0, 64'hB,       16'd3, 16'd0);
        add(0, 0, 1, 64'hB,        0, 0,  1, 1, 64'hA,       16'd3, 16'd0);
        add(0, 1, 1, 64'hC,        0, 0,  0, 1, 64'hA,       16'd4, 16'd0);
        add(0, 0, 0, 64'h0,        0, 0,  1, 0, 64'h0,       16'd5, 16'd1);
        // Flush while empty, with and without an incoming transfer.
        add(0, 1, 0, 64'h0,        0, 0,  1, 0, 64'h0,       16'd5, 16'd1);
        add(0, 1, 1, 64'hD,        0, 0,  1, 0, 64'h0,       16'd5, 16'd1);
        add(0, 0, 0, 64'h0,        0, 0,  1, 0, 64'h0,       16'd5, 16'd1);
        // Flush while FULL with a simultaneous in+out transfer.
        add(0, 0, 1, 64'hE,        1, 0,  1, 0, 64'h0,       16'd5, 16'd1);
        add(0, 1, 1, 64'hF,        1, 0,  1, 1, 64'hE,       16'd5, 16'd1);
        add(0, 0, 0, 64'h0,        0, 0,  1, 0, 64'h0,       16'd5, 16'd2);
        // Stall saturation at 15 on the 4-bit counter.
        add(0, 0, 1, 64'h11,       0, 0,  1, 0, 64'h0,       16'd5, 16'd2);
        for (int k = 0; k < 13; k++) begin
            add(0, 0, 0, 64'h0,    0, 0,  1, 1, 64'h11,      16'((5 + k > 15) ? 15 : 5 + k), 16'd2);
        end
        add(0, 0, 0, 64'h0,        0, 1,  1, 1, 64'h11,      16'd15, 16'd2);
        add(0, 0, 0, 64'h0,        0, 0,  1, 1, 64'h11,      16'd0, 16'd0);
        // cnt_clr and counted flush together: flush_cnt stays 0.
        add(0, 1, 0, 64'h0,        0, 1,  1, 1, 64'h11,      16'd1, 16'd0);
        add(0, 0, 0, 64'h0,        0, 0,  1, 0, 64'h0,       16'd0, 16'd0);
        // Single-entry instance: combinational ready, replace without bubble.
        add(1, 0, 1, 64'h21,       0, 0,  1, 0, 64'h0,       16'd0, 16'd0);
        add(1, 0, 1, 64'h22,       0, 0,  0, 1, 64'h21,      16'd0, 16'd0);
        add(1, 0, 1, 64'h22,       1, 0,  1, 1, 64'h21,      16'd1, 16'd0);
        add(1, 0, 0, 64'h0,        0, 0,  0, 1, 64'h22,      16'd1, 16'd0);
        // Flush without clearing: payload held, valid dropped.
        add(1, 1, 0, 64'h0,        0, 0,  0, 1, 64'h22,      16'd2, 16'd0);
        add(1, 0, 0, 64'h0,        0, 0,  1, 0, 64'h22,      16'd3, 16'd1);
        add(1, 1, 1, 64'h23,       0, 0,  1, 0, 64'h22,      16'd3, 16'd1);
        add(1, 0, 0, 64'h0,        0, 0,  1, 0, 64'h22,      16'd3, 16'd1);
        add(1, 0, 1, 64'h31,       1, 0,  1, 0, 64'h22,      16'd3, 16'd1);
        add(1, 0, 1, 64'h32,       1, 0,  1, 1, 64'h31,      16'd3, 16'd1);
        add(1, 0, 0, 64'h0,        1, 0,  1, 1, 64'h32,      16'd3, 16'd1);
        add(1, 0, 0, 64'h0,        1, 0,  1, 0, 64'h32,      16'd3, 16'd1);

        // Reset values while rst is held.
        #12;
        chk("rst a in_ready",  64'(a_in_ready),  64'h1);
        chk("rst a out_valid", 64'(a_out_valid), 64'h0);
        chk("rst a out_data",  a_out_data,       64'h0);
        chk("rst a stall_cnt", 64'(a_stall_cnt), 64'h0);
        chk("rst b in_ready",  64'(b_in_ready),  64'h1);
        chk("rst b out_valid", 64'(b_out_valid), 64'h0);
        chk("rst b flush_cnt", 64'(b_flush_cnt), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i], i);
        end

        // Asynchronous reset between edges while FULL with a stall counted.
        @(negedge clk);
        a_flush = 1'b0; a_cnt_clr = 1'b0;
        a_in_valid = 1'b1; a_in_data = 64'h55; a_out_ready = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("pre-rst out_valid", 64'(a_out_valid), 64'h1);
        chk("pre-rst out_data",  a_out_data,       64'h55);
        chk("pre-rst stall_cnt", 64'(a_stall_cnt), 64'h1);
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 64'(a_out_valid), 64'h0);
        chk("async rst out_data",  a_out_data,       64'h0);
        chk("async rst stall_cnt", 64'(a_stall_cnt), 64'h0);
        chk("async rst in_ready",  64'(a_in_ready),  64'h1);
        // No transfer is taken while rst stays high across an edge.
        a_in_valid = 1'b1; a_in_data = 64'h77;
        @(negedge clk);
        @(negedge clk);
        chk("rst held out_valid", 64'(a_out_valid), 64'h0);
        rst = 1'b0;
        a_in_data = 64'h66; a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        chk("post-rst out_valid", 64'(a_out_valid), 64'h1);
        chk("post-rst out_data",  a_out_data,       64'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_pipe_reg.md
# decode_pipe_reg

Parametrised inter-stage pipeline register replacing fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque WIDTH-bit payload (control bundle, PC, operands) and adds a valid/ready handshake, backpressure via an optional skid entry, and synchronous flush. It also counts stall and flush events for performance analysis. Each stage boundary instantiates one copy; the producer stage drives the in_* side and the consumer stage drives the out_* side.

## Interface
- WIDTH, 64: payload width in bits (>=1).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CLEAR_ON_FLUSH, 1: 1 = payload registers zeroed on flush; 0 = only valid bits cleared.
- CNT_W, 16: width of performance counters (>=2).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held and incoming entries.
- in_valid  in  1  producer has payload.
- in_ready  out  1  block can accept payload this cycle.
- in_data  in  WIDTH  producer payload.
- out_valid  out  1  main entry holds valid payload.
- out_ready  in  1  consumer accepts payload this cycle.
- out_data  out  WIDTH  main-entry payload.
- cnt_clr  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1, out_ready=0.
- flush_cnt  out  CNT_W  saturating count of flush cycles that discarded >=1 valid entry.

## Operation
- Input transfer: in_valid && in_ready at rising edge. Output transfer: out_valid && out_ready.
- Storage: main entry (drives out_*), skid entry (SKID=1 only). Order strictly FIFO; no payload duplicated or dropped except by flush.
- States (SKID=1): EMPTY (no valid), FULL (main valid), SKID (main+skid valid).
  - EMPTY: in xfer -> FULL, main<=in_data.
  - FULL: in+out xfer -> FULL, main<=in_data; in xfer only -> SKID, skid<=in_data; out xfer only -> EMPTY.
  - SKID: in_ready=0; out xfer -> FULL, main<=skid; else hold.
  - in_ready = (state != SKID), purely from registers.
- SKID=0: states EMPTY/FULL only; in_ready = !out_valid || out_ready (combinational); EMPTY/FULL transitions as above.
- out_data stable while out_valid=1 and out_ready=0.
- flush (below rst, above all else): next state EMPTY, both valid bits 0; input transfer in flush cycle discarded; payload regs <=0 if CLEAR_ON_FLUSH=1, else held. in_ready keeps normal formula in flush cycle.
- Counters: priority rst > cnt_clr > increment. stall_cnt +1 each cycle out_valid && !out_ready; flush_cnt +1 on flush when any entry valid. Both saturate at 2^CNT_W-1, never wrap. cnt_clr and flush same cycle: flush_cnt=0.

## Timing
- Reset values: state EMPTY, out_valid 0, out_data 0, skid payload 0, stall_cnt 0, flush_cnt 0, in_ready 1 (no transfer recognised while rst high).
- Reset mid-operation: all entries dropped immediately (asynchronous); first transfer possible on first rising edge after rst deasserts.
- Latency: in accept at edge N -> out_valid=1, out_data=payload after edge N (visible cycle N+1).
- Throughput: 1 transfer/cycle with out_ready held 1, both SKID settings.
- SKID=1: in_ready falls the cycle after the entry enters SKID; rises the cycle after main is refilled from skid.
- Counters update on same edge as triggering condition; visible next cycle.

## Test plan
- Reset/streaming: WIDTH=64, out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles one cycle behind input, stall_cnt=0.
- Backpressure SKID=1: push 0xA,0xB with out_ready=0 -> state SKID, in_ready=0, out_data=0xA held, stall_cnt counts 1 per cycle; raise out_ready -> 0xA then 0xB, in_ready=1 one cycle after 0xA leaves.
- Backpressure SKID=0: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> replace in one cycle, no bubble.
- Flush: state SKID holding 0xA,0xB, flush=1 with in_valid=1/in_data=0xC -> next cycle out_valid=0, out_data=0 (CLEAR_ON_FLUSH=1), 0xC never emitted, flush_cnt=1; flush while EMPTY -> flush_cnt unchanged.
- Saturation/clear: CNT_W=4, hold out_ready=0 20 cycles -> stall_cnt=15 and stays; cnt_clr=1 -> 0 next cycle.
- Async reset mid-stream: assert rst between edges with FULL -> out_valid=0 immediately, counters 0, in_ready=1.
